// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and constants for the seven-segment scan controller
// Contents: converter FSM state enum, active-low segment codes (a..g,dp),
// one-cold anode patterns indexed by digit, displayable limit, segment encoder.
package seg_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_LOAD
  } conv_state_t;

  // Active-low codes, bit7..bit1 = a..g, bit0 = dp (always off).
  localparam logic [7:0] SEG_0     = 8'b00000011;
  localparam logic [7:0] SEG_1     = 8'b10011111;
  localparam logic [7:0] SEG_2     = 8'b00100101;
  localparam logic [7:0] SEG_3     = 8'b00001101;
  localparam logic [7:0] SEG_4     = 8'b10011001;
  localparam logic [7:0] SEG_5     = 8'b01001001;
  localparam logic [7:0] SEG_6     = 8'b01000001;
  localparam logic [7:0] SEG_7     = 8'b00011111;
  localparam logic [7:0] SEG_8     = 8'b00000001;
  localparam logic [7:0] SEG_9     = 8'b00001001;
  localparam logic [7:0] SEG_DASH  = 8'b11111101;
  localparam logic [7:0] SEG_BLANK = 8'b11111111;

  // AN_ONE_COLD[i] drives only an[i] low.
  localparam logic [3:0][3:0] AN_ONE_COLD = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  localparam int unsigned BCD_LIMIT = 9999;

  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble binary to 4-digit BCD converter
// Ports: clk, rst (sync, active-high); nb_data/nb_valid/nb_ready value handshake;
// digits (4 BCD nibbles, units in [3:0]) and ovf, both updated only in LOAD.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int NB_W = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NB_W-1:0] nb_data,
  input  logic            nb_valid,
  output logic            nb_ready,
  output logic [15:0]     digits,
  output logic            ovf
);

  localparam int CNT_W = $clog2(NB_W + 1);

  conv_state_t      state;
  logic [NB_W-1:0]  bin_sr;
  logic [19:0]      bcd_sr;
  logic [CNT_W-1:0] iter;
  logic [15:0]      low_adj;

  // Ready is masked by rst so it reads 0 for the whole reset pulse.
  assign nb_ready = (state == S_IDLE) && !rst;

  // Add-3 step on the four displayable nibbles. The overflow nibble only
  // collects the ten-thousands carry and never reaches 5 for 5-nibble widths.
  always_comb begin
    low_adj = bcd_sr[15:0];
    for (int i = 0; i < 4; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) begin
        low_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      bin_sr <= '0;
      bcd_sr <= '0;
      iter   <= '0;
      digits <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (nb_valid) begin
            bin_sr <= nb_data;
            bcd_sr <= '0;
            iter   <= '0;
            state  <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_sr <= {bcd_sr[18:16], low_adj, bin_sr[NB_W-1]};
          bin_sr <= bin_sr << 1;
          iter   <= iter + 1'b1;
          if (iter == CNT_W'(NB_W - 1)) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // A nonzero ten-thousands nibble means the value exceeded BCD_LIMIT.
          digits <= bcd_sr[15:0];
          ovf    <= (bcd_sr[19:16] != 4'd0);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit seven-segment scan controller with BCD conversion
// Ports: myclk, rst (sync, active-high); nb_data/nb_valid/nb_ready value handshake;
// blank_lz leading-zero blanking; seg (active-low a..g,dp) and an (active-low anodes).
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NB_W     = 14,
  parameter int PRESCALE = 50000
) (
  input  logic            myclk,
  input  logic            rst,
  input  logic [NB_W-1:0] nb_data,
  input  logic            nb_valid,
  output logic            nb_ready,
  input  logic            blank_lz,
  output logic [7:0]      seg,
  output logic [3:0]      an
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] ps_cnt;
  logic            tick;
  logic [1:0]      idx;
  logic [1:0]      idx_next;
  logic [15:0]     digits;
  logic            ovf;
  logic [3:0]      nib;
  logic            blank_this;
  logic [7:0]      seg_next;

  bin2bcd_seq #(
    .NB_W(NB_W)
  ) u_conv (
    .clk     (myclk),
    .rst     (rst),
    .nb_data (nb_data),
    .nb_valid(nb_valid),
    .nb_ready(nb_ready),
    .digits  (digits),
    .ovf     (ovf)
  );

  assign tick     = (ps_cnt == PS_W'(PRESCALE - 1));
  assign idx_next = idx + 2'd1;

  // Segment pattern for the digit about to be selected, built from the
  // current display registers so a LOAD on the same edge is seen next tick.
  always_comb begin
    nib        = digits[{idx_next, 2'b00} +: 4];
    blank_this = 1'b0;
    if (blank_lz) begin
      case (idx_next)
        2'd1:    blank_this = (digits[15:4] == 12'd0);
        2'd2:    blank_this = (digits[15:8] == 8'd0);
        2'd3:    blank_this = (digits[15:12] == 4'd0);
        default: blank_this = 1'b0;
      endcase
    end
    if (ovf) begin
      seg_next = SEG_DASH;
    end else if (blank_this) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = seg_encode(nib);
    end
  end

  always_ff @(posedge myclk) begin
    if (rst) begin
      ps_cnt <= '0;
      idx    <= 2'd3;
      an     <= 4'b1111;
      seg    <= SEG_BLANK;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      if (tick) begin
        idx <= idx_next;
        an  <= AN_ONE_COLD[idx_next];
        seg <= seg_next;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (PRESCALE=4, NB_W=14)
module tb_seg_scan_ctrl;

  localparam int NB_W     = 14;
  localparam int PRESCALE = 4;

  logic            myclk = 1'b0;
  logic            rst = 1'b1;
  logic [NB_W-1:0] nb_data = '0;
  logic            nb_valid = 1'b0;
  logic            nb_ready;
  logic            blank_lz = 1'b0;
  logic [7:0]      seg;
  logic [3:0]      an;

  int checks = 0;
  int failures = 0;

  logic [7:0] segs_tab [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
                                8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
                                8'b00000001, 8'b00001001};
  logic [7:0] cap [4];

  seg_scan_ctrl #(
    .NB_W    (NB_W),
    .PRESCALE(PRESCALE)
  ) dut (
    .myclk   (myclk),
    .rst     (rst),
    .nb_data (nb_data),
    .nb_valid(nb_valid),
    .nb_ready(nb_ready),
    .blank_lz(blank_lz),
    .seg     (seg),
    .an      (an)
  );

  always #5 myclk = ~myclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what digit d should show for value v, from decimal arithmetic.
  function automatic logic [7:0] exp_seg(input int v, input bit blank, input int d);
    int p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    if (v > 9999) return 8'b11111101;
    if (blank && d > 0 && v < p) return 8'hFF;
    return segs_tab[(v / p) % 10];
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!nb_ready && n < 100) begin
      @(negedge myclk);
      n++;
    end
    check("wait_ready", {31'd0, nb_ready}, 32'd1);
  endtask

  // Single transfer; returns number of cycles nb_ready stayed low afterwards.
  task automatic send_value(input int v, output int low);
    wait_ready();
    nb_data  = NB_W'(v);
    nb_valid = 1'b1;
    @(posedge myclk);
    #1 nb_valid = 1'b0;
    nb_data = NB_W'($urandom);
    low = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge myclk);
      if (nb_ready) break;
      low++;
    end
  endtask

  // Let a full frame of new data pass, then record one frame by anode.
  task automatic capture_frame();
    for (int d = 0; d < 4; d++) cap[d] = 8'hxx;
    repeat (20) @(negedge myclk);
    for (int c = 0; c < 16; c++) begin
      @(negedge myclk);
      case (an)
        4'b1110: cap[0] = seg;
        4'b1101: cap[1] = seg;
        4'b1011: cap[2] = seg;
        4'b0111: cap[3] = seg;
        default: check("an_one_cold", {28'd0, an}, 32'he);
      endcase
    end
  endtask

  task automatic check_display(input string tag, input int v, input bit blank);
    capture_frame();
    for (int d = 0; d < 4; d++) begin
      check($sformatf("%s_d%0d", tag, d), {24'd0, cap[d]}, {24'd0, exp_seg(v, blank, d)});
    end
  endtask

  initial begin
    int low;
    int v;
    int acc;
    int t1;
    int t2;
    bit b;

    // Reset state.
    repeat (3) @(posedge myclk);
    @(negedge myclk);
    check("rst_ready", {31'd0, nb_ready}, 32'd0);
    check("rst_an", {28'd0, an}, 32'hf);
    check("rst_seg", {24'd0, seg}, 32'hff);
    rst = 1'b0;
    #1 check("ready_after_rst", {31'd0, nb_ready}, 32'd1);

    // First tick lands on the 4th edge after release, then every 4 cycles.
    for (int i = 1; i <= 3; i++) begin
      @(negedge myclk);
      check($sformatf("pre_tick_an_%0d", i), {28'd0, an}, 32'hf);
      check($sformatf("pre_tick_seg_%0d", i), {24'd0, seg}, 32'hff);
    end
    for (int j = 0; j < 5; j++) begin
      logic [3:0] e_an;
      repeat ((j == 0) ? 1 : 4) @(negedge myclk);
      e_an = ~(4'b0001 << (j % 4));
      check($sformatf("scan_an_%0d", j), {28'd0, an}, {28'd0, e_an});
      check($sformatf("scan_seg_%0d", j), {24'd0, seg}, 32'h03);
    end

    // 1234, no blanking.
    send_value(1234, low);
    check("busy_1234", low, 32'd15);
    check_display("v1234", 1234, 1'b0);

    // 7 with and without blanking.
    blank_lz = 1'b1;
    send_value(7, low);
    check("busy_7", low, 32'd15);
    check_display("v7_blank", 7, 1'b1);
    blank_lz = 1'b0;
    check_display("v7_noblank", 7, 1'b0);

    // 0 with blanking keeps the units digit.
    blank_lz = 1'b1;
    send_value(0, low);
    check_display("v0_blank", 0, 1'b1);

    // Overflow, ignoring blanking, then the largest displayable value.
    send_value(10000, low);
    check_display("v10000", 10000, 1'b1);
    blank_lz = 1'b0;
    send_value(16383, low);
    check_display("v16383", 16383, 1'b0);
    send_value(9999, low);
    check("busy_9999", low, 32'd15);
    check_display("v9999", 9999, 1'b0);

    // Random values against the decimal model.
    for (int r = 0; r < 6; r++) begin
      v = $urandom_range(0, 16383);
      if (r % 2 == 0) v = v % 1000;
      b = 1'($urandom);
      blank_lz = b;
      send_value(v, low);
      check($sformatf("busy_rand%0d", r), low, 32'd15);
      check_display($sformatf("rand%0d", r), v, b);
    end
    blank_lz = 1'b0;

    // Back-to-back valid: second value waits for ready, last value wins.
    wait_ready();
    nb_data  = NB_W'(4321);
    nb_valid = 1'b1;
    acc = 0;
    t1 = 0;
    t2 = 0;
    for (int c = 0; c < 100 && acc < 2; c++) begin
      if (nb_ready) begin
        acc++;
        if (acc == 1) t1 = c;
        else t2 = c;
      end
      @(posedge myclk);
      #1;
      if (acc == 1) nb_data = NB_W'(56);
      if (acc == 2) nb_valid = 1'b0;
      @(negedge myclk);
    end
    check("b2b_accepts", acc, 32'd2);
    check("b2b_spacing", t2 - t1, 32'd16);
    wait_ready();
    check_display("b2b_last", 56, 1'b0);

    // Reset in the middle of a conversion discards it.
    send_value(2468, low);
    check_display("pre_abort", 2468, 1'b0);
    wait_ready();
    nb_data  = NB_W'(1357);
    nb_valid = 1'b1;
    @(posedge myclk);
    #1 nb_valid = 1'b0;
    repeat (4) @(posedge myclk);
    #1 rst = 1'b1;
    repeat (2) @(posedge myclk);
    @(negedge myclk);
    rst = 1'b0;
    #1 check("abort_ready", {31'd0, nb_ready}, 32'd1);
    low = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge myclk);
      if (!nb_ready) low++;
    end
    check("abort_no_busy", low, 32'd0);
    check_display("abort", 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
